riscv_fetch_align_fifo: RTL and testbench

//  Parametrised prefetch FIFO with instruction realignment for the fetch stage.

---
 rtl/riscv_fetch_align_fifo.sv | 137 +++++++++++++
 tb/tb_riscv_fetch_align_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_align_fifo.sv
// Prefetch FIFO with 16/32-bit instruction realignment for the fetch stage.
// Keeps up to MAX_OUTSTANDING memory requests in flight and tags the stream with the last redirect's DIFT tag.
module riscv_fetch_align_fifo #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TAG_WIDTH       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_i,
  input  logic                 branch_i,
  input  logic [31:0]          branch_addr_i,
  input  logic [TAG_WIDTH-1:0] branch_tag_i,
  output logic                 instr_req_o,
  output logic [31:0]          instr_addr_o,
  input  logic                 instr_gnt_i,
  input  logic                 instr_rvalid_i,
  input  logic [31:0]          instr_rdata_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          rdata_o,
  output logic [31:0]          addr_o,
  output logic                 is_compressed_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]          mem_data [DEPTH];
  logic [29:0]          mem_addr [DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count, outstanding, discard, out_next;
  logic                 started, offset;
  logic [29:0]          fetch_word, resp_word;
  logic [TAG_WIDTH-1:0] tag;

  logic        gnt_ok, rsp_ok, drop, push, pop, consume;
  logic        avail, comp;
  logic [31:0] w0, w1, inst;
  logic [29:0] a0;
  logic        unused_bit0;

  assign unused_bit0 = branch_addr_i[0];

  // Credit check counts in-flight requests so a returning word always has a free slot.
  assign instr_req_o  = req_i & started & ~branch_i
                      & (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH))
                      & (outstanding < CW'(MAX_OUTSTANDING));
  assign instr_addr_o = {fetch_word, 2'b00};

  assign gnt_ok   = instr_req_o & instr_gnt_i;
  assign rsp_ok   = instr_rvalid_i & (outstanding != '0);
  assign drop     = rsp_ok & (discard != '0);
  assign push     = rsp_ok & ~drop & ~branch_i;
  assign out_next = outstanding + CW'(gnt_ok) - CW'(rsp_ok);

  assign w0 = mem_data[rd_ptr];
  assign w1 = mem_data[rd_ptr + AW'(1)];
  assign a0 = mem_addr[rd_ptr];

  always_comb begin
    inst  = w0;
    comp  = 1'b0;
    avail = 1'b0;
    if (!offset) begin
      inst  = w0;
      comp  = (w0[1:0] != 2'b11);
      avail = (count != '0);
    end else begin
      comp  = (w0[17:16] != 2'b11);
      inst  = comp ? {16'h0000, w0[31:16]} : {w1[15:0], w0[31:16]};
      avail = comp ? (count != '0) : (count >= CW'(2));
    end
  end

  assign valid_o         = avail & ~branch_i;
  assign consume         = valid_o & ready_i;
  // A word is retired once its upper halfword has been used.
  assign pop             = consume & (offset | ~comp);
  assign rdata_o         = valid_o ? inst : '0;
  assign addr_o          = valid_o ? {a0, offset, 1'b0} : '0;
  assign is_compressed_o = valid_o & comp;
  assign tag_o           = tag;
  assign busy_o          = (outstanding != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= instr_rdata_i;
      mem_addr[wr_ptr] <= resp_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      started     <= 1'b0;
      offset      <= 1'b0;
      fetch_word  <= '0;
      resp_word   <= '0;
      tag         <= '0;
    end else begin
      outstanding <= out_next;
      if (gnt_ok) fetch_word <= fetch_word + 30'd1;
      if (branch_i) begin
        // Everything still in flight after this cycle belongs to the old stream.
        started    <= 1'b1;
        fetch_word <= branch_addr_i[31:2];
        resp_word  <= branch_addr_i[31:2];
        offset     <= branch_addr_i[1];
        tag        <= branch_tag_i;
        discard    <= out_next;
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (drop) discard <= discard - CW'(1);
        if (push) begin
          wr_ptr    <= wr_ptr + AW'(1);
          resp_word <= resp_word + 30'd1;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (consume) offset <= offset ^ comp;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == CW'(DEPTH)));

endmodule

// File: tb/tb_riscv_fetch_align_fifo.sv
// Directed bench for riscv_fetch_align_fifo with a 1-cycle grant/response memory model.
module tb_riscv_fetch_align_fifo;

  logic        clk = 1'b0;
  logic        rst_n, req_i, branch_i, ready_i;
  logic [31:0] branch_addr_i;
  logic [0:0]  branch_tag_i;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        valid_o, is_compressed_o, busy_o;
  logic [31:0] rdata_o, addr_o;
  logic [0:0]  tag_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] pend[$];
  logic rsp_en = 1'b1;

  always #5 clk = ~clk;

  riscv_fetch_align_fifo #(.DEPTH(4), .MAX_OUTSTANDING(2), .TAG_WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .branch_tag_i(branch_tag_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .rdata_o(rdata_o), .addr_o(addr_o),
    .is_compressed_o(is_compressed_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  function automatic logic [31:0] mem_word(logic [31:0] a);
    case (a)
      32'h200: return 32'h0001_1234;
      32'h204: return 32'h0001_4501;
      32'h300: return 32'h0093_1111;
      32'h304: return 32'h0001_0000;
      default: return {a[29:2], 4'b0011};
    endcase
  endfunction

  // Memory: grant whatever is requested, answer one cycle later in order.
  initial begin
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rsp_en && pend.size() > 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(pend.pop_front());
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
      end
      @(negedge clk);
      instr_gnt_i = (instr_req_o === 1'b1);
      if (instr_gnt_i) pend.push_back(instr_addr_o);
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_instr(string tag, logic [31:0] a, logic [31:0] d, logic c, int max_wait);
    int n = 0;
    @(negedge clk);
    while (!valid_o && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    if (valid_o) begin
      check({tag, "_addr"}, addr_o, a);
      check({tag, "_c"}, 32'(is_compressed_o), 32'(c));
      check({tag, "_data"}, c ? {16'h0, rdata_o[15:0]} : rdata_o, c ? {16'h0, d[15:0]} : d);
    end
  endtask

  task automatic do_branch(logic [31:0] a, logic t);
    @(posedge clk); #1;
    branch_i = 1'b1; branch_addr_i = a; branch_tag_i = t;
    @(negedge clk);
    check("branch_valid", 32'(valid_o), 32'd0);
    check("branch_req", 32'(instr_req_o), 32'd0);
    @(posedge clk); #1;
    branch_i = 1'b0;
  endtask

  task automatic set_ready(logic v);
    @(posedge clk); #1;
    ready_i = v;
  endtask

  task automatic check_idle(string tag);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_req"},   32'(instr_req_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
    check({tag, "_iaddr"}, instr_addr_o, 32'd0);
    check({tag, "_addr"},  addr_o, 32'd0);
    check({tag, "_rdata"}, rdata_o, 32'd0);
    check({tag, "_c"},     32'(is_compressed_o), 32'd0);
    check({tag, "_tag"},   32'(tag_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_i = 1'b1; branch_i = 1'b0; ready_i = 1'b1;
    branch_addr_i = '0; branch_tag_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_req_before_branch", 32'(instr_req_o), 32'd0);

    // Sequential 32-bit stream, one instruction per cycle once primed.
    do_branch(32'h100, 1'b0);
    for (int i = 0; i < 4; i++)
      expect_instr("seq", 32'h100 + 32'(4 * i), mem_word(32'h100 + 32'(4 * i)), 1'b0, (i == 0) ? 8 : 0);

    // Compressed instructions, starting on an upper halfword.
    do_branch(32'h202, 1'b0);
    expect_instr("c202", 32'h202, 32'h0000_0001, 1'b1, 8);
    expect_instr("c204", 32'h204, 32'h0000_4501, 1'b1, 2);
    expect_instr("c206", 32'h206, 32'h0000_0001, 1'b1, 2);
    expect_instr("w208", 32'h208, 32'h0000_0823, 1'b0, 2);

    // 32-bit instruction straddling two words.
    do_branch(32'h302, 1'b0);
    expect_instr("s302", 32'h302, 32'h0000_0093, 1'b0, 8);
    expect_instr("c306", 32'h306, 32'h0000_0001, 1'b1, 2);
    expect_instr("w308", 32'h308, 32'h0000_0c23, 1'b0, 2);

    // Two responses held in flight, then two redirects before they return.
    rsp_en = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_busy", 32'(busy_o), 32'd1);
    check("hold_req", 32'(instr_req_o), 32'd0);
    do_branch(32'h500, 1'b0);
    do_branch(32'h400, 1'b1);
    @(negedge clk);
    rsp_en = 1'b1;
    expect_instr("b400", 32'h400, 32'h0000_1003, 1'b0, 12);
    check("b400_tag", 32'(tag_o), 32'd1);

    // Consumer stall: FIFO fills, requests stop, nothing is lost afterwards.
    set_ready(1'b0);
    repeat (10) @(negedge clk);
    check("stall_req", 32'(instr_req_o), 32'd0);
    check("stall_busy", 32'(busy_o), 32'd0);
    check("stall_valid", 32'(valid_o), 32'd1);
    check("stall_addr", addr_o, 32'h404);
    set_ready(1'b1);
    for (int i = 1; i <= 5; i++)
      expect_instr("drain", 32'h400 + 32'(4 * i), mem_word(32'h400 + 32'(4 * i)), 1'b0, (i == 5) ? 2 : 0);

    // Reset with responses pending; the late responses must be ignored.
    rsp_en = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    rsp_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_idle("late_rvalid");

    do_branch(32'h100, 1'b0);
    expect_instr("restart", 32'h100, 32'h0000_0403, 1'b0, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
